riscv_wb_port_arbiter: RTL and testbench

RISCV_WB_PORT_ARBITER -- requirements
Module: riscv_wb_port_arbiter

---
 rtl/riscv_wb_arb_pkg.sv | 28 ++
 rtl/riscv_wb_rr_pick2.sv | 69 ++++++
 rtl/riscv_wb_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_riscv_wb_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// riscv_wb_arb_pkg
// Shared definitions for the register-file writeback port arbiter:
//   - requester index constants (which execution unit sits on which req_i bit)
//   - wb_req_t: one writeback request {addr, data} at the default core widths
//   - wrap_inc: index increment with wrap-around modulo the requester count
// -----------------------------------------------------------------------------
package riscv_wb_arb_pkg;

   localparam int WB_ALU  = 0;
   localparam int WB_MULT = 1;
   localparam int WB_LSU  = 2;
   localparam int WB_FPU  = 3;

   localparam int WB_NUM_REQ = 4;
   localparam int WB_ADDR_W  = 6;   // integer + FP register space
   localparam int WB_DATA_W  = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/riscv_wb_rr_pick2.sv
// -----------------------------------------------------------------------------
// riscv_wb_rr_pick2
// Round-robin selection of up to two winners from a request vector.
// The search starts at ptr_i and wraps modulo N. The first requester found is
// winner 0; winner 1 is the next requester in the same order that does not
// collide with winner 0 according to block_i.
//
// Ports
//   req_i    [N-1:0]    request vector
//   ptr_i    [PW-1:0]   search start index
//   block_i  [N*N-1:0]  block_i[i*N+j] = 1 : j may not be paired with winner i
//   win0_o   [N-1:0]    one-hot first winner
//   win1_o   [N-1:0]    one-hot second winner
//   vld0_o / vld1_o     winner present flags
// -----------------------------------------------------------------------------
module riscv_wb_rr_pick2 #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]   req_i,
   input  logic [PW-1:0]  ptr_i,
   input  logic [N*N-1:0] block_i,
   output logic [N-1:0]   win0_o,
   output logic [N-1:0]   win1_o,
   output logic           vld0_o,
   output logic           vld1_o
);

   logic [N-1:0] row;

   // Offset k from the pointer maps to requester i when (ptr + k) mod N == i.
   // The double loop keeps every select on a constant index.
   always_comb begin
      int pos;
      pos    = 0;
      win0_o = '0;
      win1_o = '0;
      vld0_o = 1'b0;
      vld1_o = 1'b0;
      row    = '0;

      for (int k = 0; k < N; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         for (int i = 0; i < N; i++) begin
            if (!vld0_o && req_i[i] && (pos == i)) begin
               win0_o[i] = 1'b1;
               vld0_o    = 1'b1;
            end
         end
      end

      for (int i = 0; i < N; i++) begin
         if (win0_o[i]) row = block_i[i*N +: N];
      end

      for (int k = 0; k < N; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         for (int i = 0; i < N; i++) begin
            if (!vld1_o && req_i[i] && !win0_o[i] && !row[i] && (pos == i)) begin
               win1_o[i] = 1'b1;
               vld1_o    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/riscv_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_wb_port_arbiter
// Arbitrates NUM_REQ writeback requesters (ALU, MULT, LSU, FPU) onto the two
// register-file write ports. Up to two grants per cycle; the first winner
// drives port A, the second port B (port B wins inside the register file, so a
// lone grant always goes to A). Two requests to the same non-zero register are
// never granted together. Writes to register 0 are granted but drive we low.
// Grants are combinational; the port drive is registered (latency 1).
//
// Handshake: a transfer completes in the cycle where req_i[i] and gnt_o[i]
// are both high; requesters hold req/addr/data stable until then, nothing is
// buffered here.
//
// Build option WB_ARB_STARVE_GUARD_EN: per-requester counters of consecutive
// ungranted cycles; a requester at STARVE_LIMIT is forced onto port A ahead of
// round-robin order (lowest index first).
//
// Ports
//   clk_int, rst_n (async, active-low)
//   req_i [NUM_REQ]                    per-requester write valid
//   req_addr_i [NUM_REQ*ADDR_WIDTH]    per-requester destination, packed by index
//   req_data_i [NUM_REQ*DATA_WIDTH]    per-requester data, packed by index
//   gnt_o [NUM_REQ]                    combinational grant
//   we_a_o/waddr_a_o/wdata_a_o         registered write port A
//   we_b_o/waddr_b_o/wdata_b_o         registered write port B
// -----------------------------------------------------------------------------
module riscv_wb_port_arbiter
   import riscv_wb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 6,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REQ      = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                             clk_int,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
   output logic [NUM_REQ-1:0]               gnt_o,
   output logic                             we_a_o,
   output logic [ADDR_WIDTH-1:0]            waddr_a_o,
   output logic [DATA_WIDTH-1:0]            wdata_a_o,
   output logic                             we_b_o,
   output logic [ADDR_WIDTH-1:0]            waddr_b_o,
   output logic [DATA_WIDTH-1:0]            wdata_b_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ADDR_WIDTH-1:0]      addr [NUM_REQ];
   logic [DATA_WIDTH-1:0]      data [NUM_REQ];
   logic [NUM_REQ*NUM_REQ-1:0] pair_block;
   logic [PTR_W-1:0]           pick_ptr;
   logic [NUM_REQ-1:0]         win0, win1;
   logic                       vld0, vld1;
   logic [PTR_W-1:0]           idx0, idx1;

   logic [PTR_W-1:0]      rr_ptr_q,  rr_ptr_d;
   logic                  we_a_q,    we_a_d;
   logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
   logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
   logic                  we_b_q,    we_b_d;
   logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
   logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr[i] = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         data[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Register 0 is never written, so equal zero addresses do not collide.
   always_comb begin
      pair_block = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if ((i != j) && (addr[i] == addr[j]) && (addr[i] != '0))
               pair_block[i*NUM_REQ + j] = 1'b1;
         end
      end
   end

`ifdef WB_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q [NUM_REQ];
   logic [CNT_W-1:0] starve_cnt_d [NUM_REQ];
   logic             starve_any;
   logic [PTR_W-1:0] starve_idx;

   // A starved requester is forced to port A by starting the search at its
   // index; port B then continues round-robin from there.
   always_comb begin
      starve_any = 1'b0;
      starve_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!starve_any && req_i[i] && (starve_cnt_q[i] == CNT_W'(STARVE_LIMIT))) begin
            starve_any = 1'b1;
            starve_idx = PTR_W'(i);
         end
      end
      pick_ptr = starve_any ? starve_idx : rr_ptr_q;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!req_i[i] || gnt_o[i])
            starve_cnt_d[i] = '0;
         else if (starve_cnt_q[i] == CNT_W'(STARVE_LIMIT))
            starve_cnt_d[i] = starve_cnt_q[i];
         else
            starve_cnt_d[i] = starve_cnt_q[i] + 1'b1;
      end
   end

   always_ff @(posedge clk_int or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) starve_cnt_q[i] <= starve_cnt_d[i];
      end
   end
`else
   assign pick_ptr = rr_ptr_q;
`endif

   riscv_wb_rr_pick2 #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_pick2 (
      .req_i   (req_i),
      .ptr_i   (pick_ptr),
      .block_i (pair_block),
      .win0_o  (win0),
      .win1_o  (win1),
      .vld0_o  (vld0),
      .vld1_o  (vld1)
   );

   assign gnt_o = win0 | win1;

   always_comb begin
      idx0 = '0;
      idx1 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win0[i]) idx0 = PTR_W'(i);
         if (win1[i]) idx1 = PTR_W'(i);
      end

      // Pointer moves past the last granted requester (port B if present).
      rr_ptr_d = rr_ptr_q;
      if (vld1)
         rr_ptr_d = PTR_W'(wrap_inc(int'(idx1), NUM_REQ));
      else if (vld0)
         rr_ptr_d = PTR_W'(wrap_inc(int'(idx0), NUM_REQ));

      // Idle ports drop we but keep the last address/data on the bus.
      we_a_d    = 1'b0;
      waddr_a_d = waddr_a_q;
      wdata_a_d = wdata_a_q;
      if (vld0) begin
         we_a_d    = (addr[idx0] != '0);
         waddr_a_d = addr[idx0];
         wdata_a_d = data[idx0];
      end

      we_b_d    = 1'b0;
      waddr_b_d = waddr_b_q;
      wdata_b_d = wdata_b_q;
      if (vld1) begin
         we_b_d    = (addr[idx1] != '0);
         waddr_b_d = addr[idx1];
         wdata_b_d = data[idx1];
      end
   end

   always_ff @(posedge clk_int or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         we_a_q    <= 1'b0;
         waddr_a_q <= '0;
         wdata_a_q <= '0;
         we_b_q    <= 1'b0;
         waddr_b_q <= '0;
         wdata_b_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         we_a_q    <= we_a_d;
         waddr_a_q <= waddr_a_d;
         wdata_a_q <= wdata_a_d;
         we_b_q    <= we_b_d;
         waddr_b_q <= waddr_b_d;
         wdata_b_q <= wdata_b_d;
      end
   end

   assign we_a_o    = we_a_q;
   assign waddr_a_o = waddr_a_q;
   assign wdata_a_o = wdata_a_q;
   assign we_b_o    = we_b_q;
   assign waddr_b_o = waddr_b_q;
   assign wdata_b_o = wdata_b_q;

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_wb_port_arbiter
// Directed-vector bench for riscv_wb_port_arbiter at default parameters.
// Inputs change 1 time unit after the rising edge; gnt_o is sampled 1 unit
// after that, registered outputs 1 unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_riscv_wb_port_arbiter;
   import riscv_wb_arb_pkg::*;

   logic        clk_int = 1'b0;
   logic        rst_n   = 1'b0;
   logic [3:0]  req_i   = '0;
   logic [23:0] req_addr_i = '0;
   logic [127:0] req_data_i = '0;
   logic [3:0]  gnt_o;
   logic        we_a_o, we_b_o;
   logic [5:0]  waddr_a_o, waddr_b_o;
   logic [31:0] wdata_a_o, wdata_b_o;

   int checks = 0;
   int errors = 0;

   riscv_wb_port_arbiter dut (
      .clk_int    (clk_int),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .req_addr_i (req_addr_i),
      .req_data_i (req_data_i),
      .gnt_o      (gnt_o),
      .we_a_o     (we_a_o),
      .waddr_a_o  (waddr_a_o),
      .wdata_a_o  (wdata_a_o),
      .we_b_o     (we_b_o),
      .waddr_b_o  (waddr_b_o),
      .wdata_b_o  (wdata_b_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_int = ~clk_int;

   task automatic step();
      @(posedge clk_int);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_i = '0;
      @(negedge clk_int);
      rst_n = 1'b1;
      step();
   endtask

   // ---------------- drivers ----------------
   task automatic set_req(input int idx, input wb_req_t r);
      req_addr_i[idx*6 +: 6]   = r.addr;
      req_data_i[idx*32 +: 32] = r.data;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      req_i = '0;
      #3;
      checks++; if (we_a_o !== 1'b0)     begin errors++; $display("FAIL reset_we_a got %b exp 0", we_a_o); end
      checks++; if (we_b_o !== 1'b0)     begin errors++; $display("FAIL reset_we_b got %b exp 0", we_b_o); end
      checks++; if (waddr_a_o !== 6'd0)  begin errors++; $display("FAIL reset_waddr_a got %0d exp 0", waddr_a_o); end
      checks++; if (wdata_b_o !== 32'd0) begin errors++; $display("FAIL reset_wdata_b got %h exp 0", wdata_b_o); end
      checks++; if (gnt_o !== 4'b0000)   begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt_o); end
      @(negedge clk_int);
      rst_n = 1'b1;
      step();
      checks++; if (we_a_o !== 1'b0)     begin errors++; $display("FAIL post_reset_we_a got %b exp 0", we_a_o); end
   endtask

   task automatic test_single();
      set_req(WB_ALU, '{addr: 6'd5, data: 32'hA5});
      req_i = 4'b0001;
      #1;
      checks++; if (gnt_o !== 4'b0001)    begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt_o); end
      step();
      req_i = '0;
      checks++; if (we_a_o !== 1'b1)      begin errors++; $display("FAIL single_we_a got %b exp 1", we_a_o); end
      checks++; if (waddr_a_o !== 6'd5)   begin errors++; $display("FAIL single_waddr_a got %0d exp 5", waddr_a_o); end
      checks++; if (wdata_a_o !== 32'hA5) begin errors++; $display("FAIL single_wdata_a got %h exp a5", wdata_a_o); end
      checks++; if (we_b_o !== 1'b0)      begin errors++; $display("FAIL single_we_b got %b exp 0", we_b_o); end
   endtask

   task automatic test_idle();
      #1;
      checks++; if (gnt_o !== 4'b0000)    begin errors++; $display("FAIL idle_gnt got %b exp 0000", gnt_o); end
      step();
      checks++; if (we_a_o !== 1'b0)      begin errors++; $display("FAIL idle_we_a got %b exp 0", we_a_o); end
      checks++; if (we_b_o !== 1'b0)      begin errors++; $display("FAIL idle_we_b got %b exp 0", we_b_o); end
      checks++; if (waddr_a_o !== 6'd5)   begin errors++; $display("FAIL idle_waddr_hold got %0d exp 5", waddr_a_o); end
      checks++; if (wdata_a_o !== 32'hA5) begin errors++; $display("FAIL idle_wdata_hold got %h exp a5", wdata_a_o); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++)
         set_req(i, '{addr: 6'(i + 1), data: 32'(8'h11 * (i + 1))});
      req_i = 4'b1111;
      #1;
      checks++; if (gnt_o !== 4'b0011)    begin errors++; $display("FAIL rr_gnt_c1 got %b exp 0011", gnt_o); end
      step();
      checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd1, 32'h11})
         begin errors++; $display("FAIL rr_port_a_c1 got %b/%0d/%h exp 1/1/11", we_a_o, waddr_a_o, wdata_a_o); end
      checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd2, 32'h22})
         begin errors++; $display("FAIL rr_port_b_c1 got %b/%0d/%h exp 1/2/22", we_b_o, waddr_b_o, wdata_b_o); end
      #1;
      checks++; if (gnt_o !== 4'b1100)    begin errors++; $display("FAIL rr_gnt_c2 got %b exp 1100", gnt_o); end
      step();
      req_i = '0;
      checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd3, 32'h33})
         begin errors++; $display("FAIL rr_port_a_c2 got %b/%0d/%h exp 1/3/33", we_a_o, waddr_a_o, wdata_a_o); end
      checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd4, 32'h44})
         begin errors++; $display("FAIL rr_port_b_c2 got %b/%0d/%h exp 1/4/44", we_b_o, waddr_b_o, wdata_b_o); end
   endtask

   // pointer is 0 on entry
   task automatic test_addr_conflict();
      set_req(WB_ALU, '{addr: 6'd9, data: 32'h900});
      set_req(WB_LSU, '{addr: 6'd9, data: 32'h902});
      req_i = 4'b0101;
      #1;
      checks++; if (gnt_o !== 4'b0001)     begin errors++; $display("FAIL conflict_gnt_c1 got %b exp 0001", gnt_o); end
      step();
      req_i = 4'b0100;
      checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd9, 32'h900})
         begin errors++; $display("FAIL conflict_port_a_c1 got %b/%0d/%h exp 1/9/900", we_a_o, waddr_a_o, wdata_a_o); end
      checks++; if (we_b_o !== 1'b0)       begin errors++; $display("FAIL conflict_we_b_c1 got %b exp 0", we_b_o); end
      #1;
      checks++; if (gnt_o !== 4'b0100)     begin errors++; $display("FAIL conflict_gnt_c2 got %b exp 0100", gnt_o); end
      step();
      req_i = '0;
      checks++; if ({we_a_o, wdata_a_o} !== {1'b1, 32'h902})
         begin errors++; $display("FAIL conflict_port_a_c2 got %b/%h exp 1/902", we_a_o, wdata_a_o); end
      checks++; if (we_b_o !== 1'b0)       begin errors++; $display("FAIL conflict_we_b_c2 got %b exp 0", we_b_o); end
   endtask

   // pointer is 3 on entry
   task automatic test_addr_zero();
      set_req(WB_MULT, '{addr: 6'd0, data: 32'hBEEF});
      req_i = 4'b0010;
      #1;
      checks++; if (gnt_o !== 4'b0010)     begin errors++; $display("FAIL zero_gnt got %b exp 0010", gnt_o); end
      step();
      req_i = '0;
      checks++; if (we_a_o !== 1'b0)       begin errors++; $display("FAIL zero_we_a got %b exp 0", we_a_o); end
      checks++; if (we_b_o !== 1'b0)       begin errors++; $display("FAIL zero_we_b got %b exp 0", we_b_o); end
      checks++; if (wdata_a_o !== 32'hBEEF) begin errors++; $display("FAIL zero_wdata_a got %h exp beef", wdata_a_o); end
   endtask

   // pointer is 2 on entry; two writes to register 0 do not collide
   task automatic test_zero_pair();
      set_req(WB_ALU,  '{addr: 6'd0, data: 32'h1});
      set_req(WB_MULT, '{addr: 6'd0, data: 32'h2});
      req_i = 4'b0011;
      #1;
      checks++; if (gnt_o !== 4'b0011)     begin errors++; $display("FAIL zero_pair_gnt got %b exp 0011", gnt_o); end
      step();
      req_i = '0;
      checks++; if ({we_a_o, we_b_o, wdata_a_o, wdata_b_o} !== {1'b0, 1'b0, 32'h1, 32'h2})
         begin errors++; $display("FAIL zero_pair_ports got %b%b/%h/%h exp 00/1/2", we_a_o, we_b_o, wdata_a_o, wdata_b_o); end
   endtask

   // pointer is 2 on entry: search 2,3,0 gives FPU on A, ALU on B
   task automatic test_wrap();
      set_req(WB_ALU, '{addr: 6'h10, data: 32'hA0});
      set_req(WB_FPU, '{addr: 6'h13, data: 32'hA3});
      req_i = 4'b1001;
      #1;
      checks++; if (gnt_o !== 4'b1001)     begin errors++; $display("FAIL wrap_gnt got %b exp 1001", gnt_o); end
      step();
      req_i = '0;
      checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'h13, 32'hA3})
         begin errors++; $display("FAIL wrap_port_a got %b/%h/%h exp 1/13/a3", we_a_o, waddr_a_o, wdata_a_o); end
      checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'h10, 32'hA0})
         begin errors++; $display("FAIL wrap_port_b got %b/%h/%h exp 1/10/a0", we_b_o, waddr_b_o, wdata_b_o); end
   endtask

   // pointer is 1 on entry
   task automatic test_reset_mid_grant();
      set_req(WB_ALU, '{addr: 6'd7, data: 32'h77});
      req_i = 4'b0001;
      #1;
      checks++; if (gnt_o !== 4'b0001)     begin errors++; $display("FAIL midrst_gnt got %b exp 0001", gnt_o); end
      step();
      checks++; if (we_a_o !== 1'b1)       begin errors++; $display("FAIL midrst_we_a_before got %b exp 1", we_a_o); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({we_a_o, we_b_o} !== 2'b00) begin errors++; $display("FAIL midrst_we_async got %b exp 00", {we_a_o, we_b_o}); end
      checks++; if (waddr_a_o !== 6'd0)    begin errors++; $display("FAIL midrst_waddr_a got %0d exp 0", waddr_a_o); end
      req_i = '0;
      @(negedge clk_int);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if ({we_a_o, we_b_o} !== 2'b00)
            begin errors++; $display("FAIL midrst_no_write_c%0d got %b exp 00", c, {we_a_o, we_b_o}); end
      end
   endtask

   // ALU, LSU and FPU all target x9, MULT targets x1. Round-robin settles on
   // LSU+MULT every cycle, so FPU never pairs and waits from cycle 1.
   task automatic test_starvation();
      logic [3:0] exp_gnt;
      do_reset();
      set_req(WB_ALU,  '{addr: 6'd9, data: 32'hC0});
      set_req(WB_MULT, '{addr: 6'd1, data: 32'hC1});
      set_req(WB_LSU,  '{addr: 6'd9, data: 32'hC2});
      set_req(WB_FPU,  '{addr: 6'd9, data: 32'hC3});
      req_i = 4'b1111;
      for (int c = 1; c <= 9; c++) begin
         #1;
         if (c == 1) exp_gnt = 4'b0011;
         else        exp_gnt = 4'b0110;
`ifdef WB_ARB_STARVE_GUARD_EN
         if (c == 9) exp_gnt = 4'b1010;
`endif
         checks++; if (gnt_o !== exp_gnt)
            begin errors++; $display("FAIL starve_gnt_c%0d got %b exp %b", c, gnt_o, exp_gnt); end
         step();
      end
      req_i = '0;
`ifdef WB_ARB_STARVE_GUARD_EN
      checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd9, 32'hC3})
         begin errors++; $display("FAIL starve_port_a got %b/%0d/%h exp 1/9/c3", we_a_o, waddr_a_o, wdata_a_o); end
`else
      checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd9, 32'hC2})
         begin errors++; $display("FAIL starve_port_a got %b/%0d/%h exp 1/9/c2", we_a_o, waddr_a_o, wdata_a_o); end
`endif
      checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd1, 32'hC1})
         begin errors++; $display("FAIL starve_port_b got %b/%0d/%h exp 1/1/c1", we_b_o, waddr_b_o, wdata_b_o); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single();
      test_idle();
      test_round_robin();
      test_addr_conflict();
      test_addr_zero();
      test_zero_pair();
      test_wrap();
      test_reset_mid_grant();
      test_starvation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
